// File: rtl/uop_sequencer_pkg.sv
// Shared controller definitions: uOP row constants, the default halt opcode
// and the sequencer state encoding.
package uop_sequencer_pkg;

  localparam logic [2:0]  UOP_FETCH          = 3'd0;
  localparam logic [2:0]  UOP_DECODE         = 3'd1;
  localparam logic [2:0]  UOP_IDLE           = 3'd7;
  localparam logic [15:0] DEFAULT_HLT_OPCODE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } seq_state_t;

endpackage

// File: rtl/uop_sequencer_flag_latch.sv
// Two-bit enable-load flag register (zero, carry) with synchronous
// active-low reset.
module flag_latch (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [1:0] i_d,
  output logic [1:0] o_q
);

  logic [1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= 2'b00;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uop_sequencer.sv
// Micro-operation sequencer: owns the uOP counter, run/halt/single-step
// control and latched ALU flags. Overrun watchdog enabled by UOP_WATCHDOG_EN.
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter logic [15:0] HLT_OPCODE = DEFAULT_HLT_OPCODE,
  parameter logic [2:0]  UOP_LIMIT  = 3'd6
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RUN,
  input  logic        STEP_REQ,
  output logic        STEP_ACK,
  input  logic [15:0] INSTR,
  input  logic        RESET_uOP,
  input  logic        READ_FLAGS,
  input  logic        ALU_ZERO,
  input  logic        ALU_COUT,
  output logic [2:0]  uOP,
  output logic        ZERO_FLAG,
  output logic        COUT_FLAG,
  output logic        HALTED,
  output logic        INSTR_DONE,
  output logic        UOP_ERR
);

  seq_state_t r_state;
  seq_state_t w_state_nx;
  logic [2:0] r_uop;
  logic [2:0] w_uop_nx;
  logic       r_done;
  logic       w_done_nx;
  logic       r_ack;
  logic       w_ack_nx;
  logic       r_hlt_lock;
  logic       w_lock_nx;
  logic       w_exec;
  logic       w_halt;
  logic       w_over;
  logic       w_boundary;
  logic [1:0] w_flags;

  assign w_exec = (r_state == ST_RUNNING) || (r_state == ST_STEPPING);
  assign w_halt = (r_uop == 3'd2) && (INSTR == HLT_OPCODE);

`ifdef UOP_WATCHDOG_EN
  assign w_over = (r_uop == UOP_LIMIT);
`else
  assign w_over = 1'b0;
`endif

  assign w_boundary = RESET_uOP || w_halt || w_over;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_uop      <= UOP_IDLE;
      r_done     <= 1'b0;
      r_ack      <= 1'b0;
      r_hlt_lock <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_uop      <= w_uop_nx;
      r_done     <= w_done_nx;
      r_ack      <= w_ack_nx;
      r_hlt_lock <= w_lock_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_uop_nx   = r_uop;
    w_done_nx  = 1'b0;
    w_ack_nx   = r_ack;
    w_lock_nx  = r_hlt_lock;

    // The handshake finishes once the requester has dropped STEP_REQ.
    if (r_ack && !STEP_REQ) w_ack_nx = 1'b0;
    if (!RUN) w_lock_nx = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_uop_nx = UOP_IDLE;
        if (RUN && !r_hlt_lock) begin
          w_state_nx = ST_RUNNING;
          w_uop_nx   = UOP_FETCH;
        end else if (STEP_REQ && !r_ack) begin
          w_state_nx = ST_STEPPING;
          w_uop_nx   = UOP_FETCH;
        end
      end
      ST_RUNNING, ST_STEPPING: begin
        if (w_boundary) begin
          w_done_nx = 1'b1;
          if (w_halt && RUN) w_lock_nx = 1'b1;
          if ((r_state == ST_RUNNING) && RUN && !w_halt) begin
            w_uop_nx = UOP_FETCH;
          end else begin
            w_state_nx = ST_IDLE;
            w_uop_nx   = UOP_IDLE;
          end
          if (r_state == ST_STEPPING) w_ack_nx = 1'b1;
        end else begin
          w_uop_nx = r_uop + 3'd1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_uop_nx   = UOP_IDLE;
      end
    endcase
  end

`ifdef UOP_WATCHDOG_EN
  logic r_err;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_err <= 1'b0;
    end else if (w_exec && w_over) begin
      r_err <= 1'b1;
    end
  end

  assign UOP_ERR = r_err;
`else
  assign UOP_ERR = 1'b0;
`endif

  flag_latch u_flags (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_load  (READ_FLAGS && w_exec),
    .i_d     ({ALU_ZERO, ALU_COUT}),
    .o_q     (w_flags)
  );

  assign uOP        = r_uop;
  assign ZERO_FLAG  = w_flags[1];
  assign COUT_FLAG  = w_flags[0];
  assign HALTED     = (r_state == ST_IDLE);
  assign INSTR_DONE = r_done;
  assign STEP_ACK   = r_ack;

endmodule
